msg_charset_checker: RTL and testbench

MSG_CHARSET_CHECKER -- requirements
Module: msg_charset_checker

---
 rtl/msg_charset_checker.sv | 186 ++++++++++++++++++
 tb/tb_msg_charset_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_charset_checker.sv
// msg_charset_checker
// Reads a MSG_LEN-byte message from a RAM, one byte at a time, and checks
// that every byte belongs to the allowed character set. Lowercase letters and
// space are always allowed. Uppercase and digits are allowed by the mode
// latched at start. The first offending address is reported, together with the
// number of bytes accepted before the scan stopped.
//
// Control handshake: start and abort are single-cycle level samples, with no
// ready/valid pair. start is honoured only in IDLE and only when abort is low
// in the same cycle. abort is honoured in every busy state and wins over any
// result computed in that cycle. done is a one-cycle pulse that is high while
// the FSM sits in DONE, and pass/fail_addr/valid_cnt are stable from that cycle
// until the next accepted start.

module msg_charset_checker #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ADDR_W:0]   valid_cnt,
   output logic [2:0]        o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MSG_LEN - 1);
   // WAIT is entered with RD_LAT-2 and left when the counter reaches zero,
   // giving RD_LAT-1 WAIT cycles. The value is unused when RD_LAT is 1.
   localparam logic [1:0]        WAIT_INIT  = 2'(RD_LAT - 2);
   localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [1:0]        r_wait_cnt;
   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rd_en;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [ADDR_W:0]   r_valid_cnt;

   logic [7:0]        w_lo;
   logic              w_hi_zero;
   logic              w_is_lower;
   logic              w_is_space;
   logic              w_is_upper;
   logic              w_is_digit;
   logic              w_byte_ok;
   logic              w_last;

   // Any bit above the low byte makes the word invalid; with an 8-bit bus
   // there is nothing above the low byte to check.
   generate
      if (DATA_W > 8) begin : g_hi_bits
         assign w_hi_zero = (rd_data[DATA_W-1:8] == '0);
      end else begin : g_no_hi_bits
         assign w_hi_zero = 1'b1;
      end
   endgenerate

   assign w_lo       = rd_data[7:0];
   assign w_is_lower = (w_lo >= 8'd97) && (w_lo <= 8'd122);
   assign w_is_space = (w_lo == 8'd32);
   assign w_is_upper = (w_lo >= 8'd65) && (w_lo <= 8'd90);
   assign w_is_digit = (w_lo >= 8'd48) && (w_lo <= 8'd57);
   assign w_byte_ok  = w_hi_zero &&
                       (w_is_lower || w_is_space ||
                        (w_is_upper && r_mode[0]) ||
                        (w_is_digit && r_mode[1]));
   assign w_last     = (r_addr == LAST_ADDR);

   // Scan FSM: every output is a register updated together with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= 2'd0;
         r_mode      <= 2'd0;
         r_addr      <= '0;
         r_rd_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_addr <= '0;
         r_valid_cnt <= '0;
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start && !abort) begin
               r_addr      <= '0;
               r_valid_cnt <= '0;
               r_pass      <= 1'b0;
               r_fail_addr <= '0;
               r_mode      <= mode;
               r_rd_en     <= 1'b1;
               r_busy      <= 1'b1;
               r_state     <= S_FETCH;
            end
         end else if (abort) begin
            // Partial valid_cnt is kept on purpose so software can see how
            // far the scan got before it was cancelled.
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_FETCH: begin
                  if (RD_LAT == 1) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_wait_cnt <= WAIT_INIT;
                     r_state    <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (r_wait_cnt == 2'd0) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_wait_cnt <= r_wait_cnt - 2'd1;
                  end
               end
               S_CHECK: begin
                  if (w_byte_ok) begin
                     r_valid_cnt <= r_valid_cnt + CNT_ONE;
                     if (w_last) begin
                        // The address stops at the last byte, so no read
                        // ever wraps to address 0.
                        r_pass  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_rd_en <= 1'b1;
                        r_state <= S_FETCH;
                     end
                  end else begin
                     r_pass      <= 1'b0;
                     r_fail_addr <= r_addr;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
               S_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign rd_addr     = r_addr;
   assign rd_en       = r_rd_en;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign fail_addr   = r_fail_addr;
   assign valid_cnt   = r_valid_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msg_charset_checker.sv
// Bench for msg_charset_checker: a default instance (32 bytes, RD_LAT=1) and a
// second instance (8 bytes, RD_LAT=3, 10-bit data), each fed by its own RAM model.
module tb_msg_charset_checker;

  localparam int SB_W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0 (defaults) ----------------
  logic       start0, abort0;
  logic [1:0] mode0;
  logic [7:0] rd_data0;
  logic [4:0] rd_addr0, fail_addr0;
  logic       rd_en0, busy0, done0, pass0;
  logic [5:0] valid_cnt0;
  logic [2:0] st0;

  msg_charset_checker dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .mode(mode0),
    .rd_data(rd_data0), .rd_addr(rd_addr0), .rd_en(rd_en0), .busy(busy0),
    .done(done0), .pass(pass0), .fail_addr(fail_addr0), .valid_cnt(valid_cnt0),
    .o_dbg_state(st0)
  );

  // ---------------- DUT 1 (8 bytes, RD_LAT=3, 10-bit data) ----------------
  logic       start1, abort1;
  logic [1:0] mode1;
  logic [9:0] rd_data1;
  logic [2:0] rd_addr1, fail_addr1;
  logic       rd_en1, busy1, done1, pass1;
  logic [3:0] valid_cnt1;
  logic [2:0] st1;

  msg_charset_checker #(.MSG_LEN(8), .ADDR_W(3), .DATA_W(10), .RD_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .mode(mode1),
    .rd_data(rd_data1), .rd_addr(rd_addr1), .rd_en(rd_en1), .busy(busy1),
    .done(done1), .pass(pass1), .fail_addr(fail_addr1), .valid_cnt(valid_cnt1),
    .o_dbg_state(st1)
  );

  // ---------------- RAM models ----------------
  // Outside a real read the RAM returns an invalid word, so sampling rd_data
  // in the wrong cycle shows up as a failure.
  logic [7:0] mem0 [32];
  logic [9:0] mem1 [8];
  logic [9:0] p1_a, p1_b;

  always @(posedge clk) rd_data0 <= rd_en0 ? mem0[rd_addr0] : 8'hFF;

  always @(posedge clk) begin
    p1_a     <= rd_en1 ? mem1[rd_addr1] : 10'h3FF;
    p1_b     <= p1_a;
    rd_data1 <= p1_b;
  end

  function automatic void fill0();
    for (int i = 0; i < 32; i++) mem0[i] = ((i % 27) < 26) ? 8'(97 + (i % 27)) : 8'd32;
  endfunction

  function automatic void fill1();
    for (int i = 0; i < 8; i++) mem1[i] = 10'(97 + i);
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [SB_W-1:0] exp_q0[$];
  logic [SB_W-1:0] exp_q1[$];
  int s_cyc0, s_cyc1;
  int nxt_addr0, nxt_addr1, last_en1;

  function automatic logic [SB_W-1:0] pk(input int lat, input logic p, input int fa, input int vc);
    return {16'(lat), p, 8'(fa), 8'(vc)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor 0: result on done, read address sequence on rd_en.
  always @(negedge clk) begin
    if (done0) begin
      if (exp_q0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done0_unexpected: got done=1 expected no done (t=%0t)", $time);
      end else begin
        check("done0_result", 64'(pk(cyc - s_cyc0, pass0, int'(fail_addr0), int'(valid_cnt0))),
              64'(exp_q0.pop_front()));
      end
    end
    if (rd_en0) begin
      check("rd_addr0_seq", 64'(rd_addr0), 64'(nxt_addr0));
      nxt_addr0++;
    end
  end

  // Monitor 1: result on done, address sequence and rd_en spacing.
  always @(negedge clk) begin
    if (done1) begin
      if (exp_q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done1_unexpected: got done=1 expected no done (t=%0t)", $time);
      end else begin
        check("done1_result", 64'(pk(cyc - s_cyc1, pass1, int'(fail_addr1), int'(valid_cnt1))),
              64'(exp_q1.pop_front()));
      end
    end
    if (rd_en1) begin
      check("rd_addr1_seq", 64'(rd_addr1), 64'(nxt_addr1));
      nxt_addr1++;
      if (last_en1 >= 0) check("rd_en1_spacing", 64'(cyc - last_en1), 64'(4));
      last_en1 = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run0(input logic [1:0] m);
    @(posedge clk); #1;
    mode0 = m; start0 = 1'b1; s_cyc0 = cyc; nxt_addr0 = 0;
    @(posedge clk); #1;
    start0 = 1'b0; mode0 = ~m;
  endtask

  task automatic start_run1(input logic [1:0] m);
    @(posedge clk); #1;
    mode1 = m; start1 = 1'b1; s_cyc1 = cyc; nxt_addr1 = 0; last_en1 = -1;
    @(posedge clk); #1;
    start1 = 1'b0; mode1 = ~m;
  endtask

  task automatic wait_idle0(input string name);
    logic seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (!busy0) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(1));
    check("done0_one_cycle", 64'(done0), 64'(0));
  endtask

  task automatic wait_idle1(input string name);
    logic seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (!busy1) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(1));
    check("done1_one_cycle", 64'(done1), 64'(0));
  endtask

  task automatic run0(input logic [1:0] m, input logic p, input int fa, input int vc);
    exp_q0.push_back(pk((p ? 32 : fa + 1) * 2 + 1, p, fa, vc));
    start_run0(m);
    wait_idle0("run0_completes");
  endtask

  task automatic run1(input logic [1:0] m, input logic p, input int fa, input int vc);
    exp_q1.push_back(pk((p ? 8 : fa + 1) * 4 + 1, p, fa, vc));
    start_run1(m);
    wait_idle1("run1_completes");
  endtask

  // Single-character table placed at byte 0: char, mode, expected ok.
  logic [7:0] tch [16];
  logic [1:0] tmd [16];
  logic       tok [16];

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; mode0 = 2'b00;
    start1 = 1'b0; abort1 = 1'b0; mode1 = 2'b00;
    nxt_addr0 = 0; nxt_addr1 = 0; last_en1 = -1; s_cyc0 = 0; s_cyc1 = 0;
    fill0(); fill1();
    tch = '{8'd32, 8'd31, 8'd97, 8'd122, 8'd96, 8'd123, 8'd65, 8'd65,
            8'd90, 8'd64, 8'd91, 8'd48, 8'd57, 8'd57, 8'd47, 8'd58};
    tmd = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01,
            2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11};
    tok = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
            1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state0", 64'({rd_addr0, fail_addr0, valid_cnt0, rd_en0, busy0, done0, pass0, st0}), 64'(0));
    check("reset_state1", 64'({rd_addr1, fail_addr1, valid_cnt1, rd_en1, busy1, done1, pass1, st1}), 64'(0));

    // Full message of lowercase/space: done 65 cycles after start.
    run0(2'b00, 1'b1, 0, 32);
    // 'A' at byte 5 under different modes, then '3' at byte 7.
    mem0[5] = 8'h41;
    run0(2'b00, 1'b0, 5, 5);
    run0(2'b01, 1'b1, 0, 32);
    mem0[7] = 8'h33;
    run0(2'b01, 1'b0, 7, 7);
    run0(2'b11, 1'b1, 0, 32);
    run0(2'b10, 1'b0, 5, 5);

    // Character-class boundaries at byte 0.
    for (int i = 0; i < 16; i++) begin
      fill0();
      mem0[0] = tch[i];
      run0(tmd[i], tok[i], 0, tok[i] ? 32 : 0);
    end

    // Last byte invalid, then results must hold in IDLE.
    fill0();
    mem0[31] = 8'h7B;
    run0(2'b11, 1'b0, 31, 31);
    repeat (5) @(negedge clk);
    check("idle_hold", 64'({pass0, fail_addr0, valid_cnt0}), 64'({1'b0, 5'd31, 6'd31}));
    // start together with abort in IDLE is ignored.
    @(posedge clk); #1 start0 = 1'b1; abort0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0; abort0 = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 64'({busy0, pass0, fail_addr0, valid_cnt0}), 64'({1'b0, 1'b0, 5'd31, 6'd31}));

    // start pulsed mid-run with a different mode must not disturb the run.
    fill0();
    mem0[5] = 8'h41;
    exp_q0.push_back(pk(65, 1'b1, 0, 32));
    start_run0(2'b01);
    repeat (4) @(posedge clk);
    #1 mode0 = 2'b00; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_idle0("midrun_start_completes");

    // Abort during the CHECK of address 10.
    fill0();
    start_run0(2'b00);
    repeat (21) @(posedge clk);
    #1 abort0 = 1'b1;
    @(posedge clk); #1 abort0 = 1'b0;
    @(negedge clk);
    check("abort0_state", 64'({busy0, done0, pass0, valid_cnt0, st0}), 64'({1'b0, 1'b0, 1'b0, 6'd10, 3'd0}));
    repeat (80) @(negedge clk);

    // Reset while fetching address 20, then a fresh full check.
    start_run0(2'b00);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_reset0", 64'({rd_addr0, fail_addr0, valid_cnt0, rd_en0, busy0, done0, pass0}), 64'(0));
    repeat (80) @(negedge clk);
    run0(2'b00, 1'b1, 0, 32);

    // Second instance: longer read latency and wide data.
    run1(2'b00, 1'b1, 0, 8);
    mem1[2] = 10'h161;
    run1(2'b11, 1'b0, 2, 2);
    mem1[2] = 10'h041;
    run1(2'b01, 1'b1, 0, 8);
    run1(2'b00, 1'b0, 2, 2);
    // Abort in the WAIT of address 3.
    fill1();
    start_run1(2'b00);
    repeat (13) @(posedge clk);
    #1 abort1 = 1'b1;
    @(posedge clk); #1 abort1 = 1'b0;
    @(negedge clk);
    check("abort1_state", 64'({busy1, done1, pass1, valid_cnt1, st1}), 64'({1'b0, 1'b0, 1'b0, 4'd3, 3'd0}));
    repeat (40) @(negedge clk);

    check("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog bounds the whole run.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
